// File: rtl/dt_backward_pass.sv
// Backward (reverse raster) pass of a two-pass distance transform over a row-major frame buffer.
// Optional DT_ZERO_SKIP_EN: zero-valued centre pixels are skipped after RD_C with no write-back.
module dt_backward_pass #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata
);

  typedef enum logic [2:0] {IDLE, RD_C, RD_E, RD_SW, RD_S, RD_SE, WR, DONE} state_t;

  localparam int                COL_W      = $clog2(IMG_W);
  localparam int                SUM_W      = PIX_W + 3;
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'((IMG_H - 2) * IMG_W + (IMG_W - 2));
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_W + 1);
  localparam logic [ADDR_W-1:0] OFF_SW     = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] OFF_S      = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] OFF_SE     = ADDR_W'(IMG_W + 1);
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_W - 2);
  localparam logic [PIX_W-1:0]  PIX_MAX    = {PIX_W{1'b1}};

  state_t             state, state_nxt;
  logic               mode_q;
  logic               advance;
  logic [ADDR_W-1:0]  cur;
  logic [COL_W-1:0]   col;
  logic [PIX_W-1:0]   pix_c, pix_e, pix_sw, pix_s, pix_se;
  logic [SUM_W-1:0]   w_orth, w_diag;
  logic [PIX_W-1:0]   cand_e, cand_sw, cand_s, cand_se, min_val;

  // Sums are formed wide so an overflowing neighbour clamps to the maximum distance instead of wrapping.
  function automatic logic [PIX_W-1:0] sat_add(input logic [PIX_W-1:0] a, input logic [SUM_W-1:0] w);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + w;
    return (s > SUM_W'(PIX_MAX)) ? PIX_MAX : s[PIX_W-1:0];
  endfunction

  function automatic logic [PIX_W-1:0] min2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  assign w_orth  = mode_q ? SUM_W'(3) : SUM_W'(1);
  assign w_diag  = mode_q ? SUM_W'(4) : SUM_W'(1);
  assign cand_e  = sat_add(pix_e, w_orth);
  assign cand_s  = sat_add(pix_s, w_orth);
  assign cand_sw = sat_add(pix_sw, w_diag);
  assign cand_se = sat_add(pix_se, w_diag);
  assign min_val = min2(min2(min2(pix_c, cand_e), min2(cand_s, cand_sw)), cand_se);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    advance   = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) state_nxt = RD_C;
      end
      RD_C: begin
        busy      = 1'b1;
        mem_rd    = 1'b1;
        mem_addr  = cur;
        state_nxt = RD_E;
`ifdef DT_ZERO_SKIP_EN
        if (mem_rdata == '0) advance = 1'b1;
`else
`endif
      end
      RD_E: begin
        busy      = 1'b1;
        mem_rd    = 1'b1;
        mem_addr  = cur + ADDR_W'(1);
        state_nxt = RD_SW;
      end
      RD_SW: begin
        busy      = 1'b1;
        mem_rd    = 1'b1;
        mem_addr  = cur + OFF_SW;
        state_nxt = RD_S;
      end
      RD_S: begin
        busy      = 1'b1;
        mem_rd    = 1'b1;
        mem_addr  = cur + OFF_S;
        state_nxt = RD_SE;
      end
      RD_SE: begin
        busy      = 1'b1;
        mem_rd    = 1'b1;
        mem_addr  = cur + OFF_SE;
        state_nxt = WR;
      end
      WR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cur;
        mem_wdata = min_val;
        advance   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (advance) state_nxt = (cur == LAST_ADDR) ? DONE : RD_C;
  end

  // The column counter avoids a modulo on cur; wrapping from col 1 jumps over both border columns.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      cur    <= '0;
      col    <= '0;
      pix_c  <= '1;
      pix_e  <= '1;
      pix_sw <= '1;
      pix_s  <= '1;
      pix_se <= '1;
    end else begin
      state <= state_nxt;
      if ((state == IDLE || state == DONE) && start) begin
        mode_q <= mode;
        cur    <= FIRST_ADDR;
        col    <= COL_LAST;
      end
      if (advance) begin
        if (col == COL_W'(1)) begin
          cur <= cur - ADDR_W'(3);
          col <= COL_LAST;
        end else begin
          cur <= cur - ADDR_W'(1);
          col <= col - COL_W'(1);
        end
      end
      case (state)
        RD_C:    pix_c  <= mem_rdata;
        RD_E:    pix_e  <= mem_rdata;
        RD_SW:   pix_sw <= mem_rdata;
        RD_S:    pix_s  <= mem_rdata;
        RD_SE:   pix_se <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dt_backward_pass.md
DT_BACKWARD_PASS -- requirements
Module: dt_backward_pass

Interface
REQ-001 SHALL have parameter IMG_W, default 128, image width in pixels (>=3).
REQ-002 SHALL have parameter IMG_H, default 128, image height in pixels (>=3).
REQ-003 SHALL have parameter PIX_W, default 8, pixel/distance width in bits.
REQ-004 SHALL have parameter ADDR_W, default 14, memory address width (2^ADDR_W >= IMG_W*IMG_H).
REQ-005 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-007 SHALL have port start, input, 1, begin one backward scan when sampled high in IDLE.
REQ-008 SHALL have port mode, input, 1, 0 = chessboard (orthogonal 1, diagonal 1), 1 = chamfer 3-4 (orthogonal 3, diagonal 4); sampled with start.
REQ-009 SHALL have port busy, output, 1, high while scan in progress.
REQ-010 SHALL have port done, output, 1, high from scan completion until next accepted start.
REQ-011 SHALL have port mem_addr, output, ADDR_W, read/write address, row-major (addr = row*IMG_W + col).
REQ-012 SHALL have port mem_rd, output, 1, read strobe.
REQ-013 SHALL have port mem_rdata, input, PIX_W, read data, valid in same cycle as mem_addr/mem_rd.
REQ-014 SHALL have port mem_we, output, 1, write strobe.
REQ-015 SHALL have port mem_wdata, output, PIX_W, write data.

Function
REQ-016 SHALL implement FSM states IDLE, RD_C, RD_E, RD_SW, RD_S, RD_SE, WR, DONE, one cycle each.
REQ-017 SHALL, on start in IDLE or DONE, latch mode, clear done, set busy, load cur = (IMG_H-2)*IMG_W + (IMG_W-2), enter RD_C.
REQ-018 SHALL visit interior pixels only (rows 1..IMG_H-2, cols 1..IMG_W-2) in reverse raster order; border pixels never read or written.
REQ-019 SHALL drive mem_rd=1 with mem_addr = cur, cur+1, cur+IMG_W-1, cur+IMG_W, cur+IMG_W+1 in RD_C, RD_E, RD_SW, RD_S, RD_SE respectively, capturing mem_rdata each cycle.
REQ-020 SHALL in WR drive mem_we=1, mem_addr=cur, mem_wdata = min(C, E+wo, S+wo, SW+wd, SE+wd), wo/wd per latched mode.
REQ-021 SHALL compute sums in PIX_W+3 bits; any sum above 2^PIX_W-1 SHALL saturate to 2^PIX_W-1 before comparison (no wrap).
REQ-022 SHALL after WR decrement cur, stepping from col 1 to col IMG_W-2 of previous row (cur-3); after WR of row 1 col 1 enter DONE.
REQ-023 SHALL in DONE hold done=1, busy=0, mem_rd=0, mem_we=0; IDLE/DONE drive mem_addr=0, mem_wdata=0.
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL per pixel take 6 cycles (RD_C..WR); total scan (IMG_H-2)*(IMG_W-2)*6 cycles, done high on following cycle.
REQ-026 SHALL never assert mem_rd and mem_we in the same cycle.

Reset
REQ-027 SHALL, on reset=0 at a clock edge, enter IDLE, busy=0, done=0, mem_rd=0, mem_we=0, mem_addr=0, mem_wdata=0, cur=0, captured pixels cleared to all-ones.
REQ-028 SHALL abort any scan in progress on reset with no further memory access; next start restarts from first pixel.

Configuration
REQ-029 SHALL support macro DT_ZERO_SKIP_EN: when defined, a pixel whose center read in RD_C is 0 SHALL skip RD_E..WR (no write), advancing cur directly (1 cycle/pixel).
REQ-030 SHALL, without DT_ZERO_SKIP_EN, process zero pixels through all 6 states and write 0.

Verification
REQ-031 SHALL cover: 8x8, mode 0, row 7 all 0, others 0xFF -> rows 6..1 cols 1..6 become 1..6; done rises 217 cycles after start edge.
REQ-032 SHALL cover: same image, mode 1 -> rows 6..1 become 3,6,9,12,15,18; border pixels unchanged.
REQ-033 SHALL cover: 8x8 interior all 0 -> with DT_ZERO_SKIP_EN done after 37 cycles, zero mem_we pulses; without, 217 cycles, 36 writes of 0.
REQ-034 SHALL cover: PIX_W=8, mode 1, C=0xFF, all neighbours 0xFE -> mem_wdata=0xFF (saturation, no wrap to 0x01).
REQ-035 SHALL cover: reset low at cycle 50 of scan -> next cycle busy=0, mem_we=0, mem_rd=0; subsequent start first reads addr 54.
REQ-036 SHALL cover: start pulsed at cycle 10 of a busy scan -> ignored, completion time unchanged.
